// File: rtl/pwf_gate_seq.sv
// Burst sequencer for the pwf_1557 pulse-width filter: drives gate g with a
// programmed pulse train, counts rising edges on the filter output i, and reports a verdict.
module pwf_gate_seq #(
    parameter int CW   = 8,
    parameter int NW   = 4,
    parameter int TAIL = 16
) (
    input  logic          clk11m,
    input  logic          rst,
    input  logic          start,
    input  logic [CW-1:0] width,
    input  logic [CW-1:0] gap,
    input  logic [NW-1:0] npulse,
    input  logic [NW-1:0] exp_edges,
    input  logic          i,
    output logic          g,
    output logic          busy,
    output logic          done,
    output logic          pass,
    output logic [NW-1:0] edges
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_PULSE = 3'd1;
    localparam logic [2:0] S_GAP   = 3'd2;
    localparam logic [2:0] S_TAILW = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
    localparam logic [CW-1:0] CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};
    localparam logic [CW-1:0] CNT_TAIL = CW'(TAIL);
    localparam logic [NW-1:0] NW_ZERO  = {NW{1'b0}};
    localparam logic [NW-1:0] NW_ONE   = {{(NW-1){1'b0}}, 1'b1};
    localparam logic [NW-1:0] NW_MAX   = {NW{1'b1}};

    logic [2:0]    state_r, state_nx_s;
    logic [CW-1:0] cnt_r, cnt_nx_s;
    logic [NW-1:0] pcnt_r, pcnt_nx_s;
    logic [CW-1:0] width_r, width_nx_s;
    logic [CW-1:0] gap_r, gap_nx_s;
    logic [NW-1:0] exp_r, exp_nx_s;
    logic [NW-1:0] edges_r, edges_nx_s;
    logic          pass_r, pass_nx_s;
    logic          done_r, done_nx_s;
    logic          g_r, busy_r;
    logic          i_q_r;
    logic          rise_s;
    logic          counting_s;
    logic [CW-1:0] gap_eff_s;

    assign g     = g_r;
    assign busy  = busy_r;
    assign done  = done_r;
    assign pass  = pass_r;
    assign edges = edges_r;

    assign rise_s     = i & ~i_q_r;
    assign counting_s = (state_r == S_PULSE) || (state_r == S_GAP) || (state_r == S_TAILW);
    // A zero gap still leaves one low cycle so consecutive pulses stay distinct.
    assign gap_eff_s  = (gap_r == CNT_ZERO) ? CNT_ONE : gap_r;

    // Next-state, counter and verdict logic.
    always_comb begin
        state_nx_s = state_r;
        cnt_nx_s   = cnt_r;
        pcnt_nx_s  = pcnt_r;
        width_nx_s = width_r;
        gap_nx_s   = gap_r;
        exp_nx_s   = exp_r;
        pass_nx_s  = pass_r;
        done_nx_s  = 1'b0;

        if (counting_s && rise_s && (edges_r != NW_MAX)) begin
            edges_nx_s = edges_r + NW_ONE;
        end else begin
            edges_nx_s = edges_r;
        end

        case (state_r)
            S_IDLE: begin
                if (start) begin
                    width_nx_s = width;
                    gap_nx_s   = gap;
                    exp_nx_s   = exp_edges;
                    edges_nx_s = NW_ZERO;
                    pass_nx_s  = 1'b0;
                    if ((width == CNT_ZERO) || (npulse == NW_ZERO)) begin
                        state_nx_s = S_DONE;
                        done_nx_s  = 1'b1;
                        pass_nx_s  = (exp_edges == NW_ZERO);
                    end else begin
                        cnt_nx_s   = width;
                        pcnt_nx_s  = npulse;
                        state_nx_s = S_PULSE;
                    end
                end else begin
                    state_nx_s = S_IDLE;
                end
            end
            S_PULSE: begin
                if (cnt_r <= CNT_ONE) begin
                    cnt_nx_s   = gap_eff_s;
                    pcnt_nx_s  = pcnt_r - NW_ONE;
                    state_nx_s = S_GAP;
                end else begin
                    cnt_nx_s = cnt_r - CNT_ONE;
                end
            end
            S_GAP: begin
                if (cnt_r <= CNT_ONE) begin
                    if (pcnt_r != NW_ZERO) begin
                        cnt_nx_s   = width_r;
                        state_nx_s = S_PULSE;
                    end else begin
                        cnt_nx_s   = CNT_TAIL;
                        state_nx_s = S_TAILW;
                    end
                end else begin
                    cnt_nx_s = cnt_r - CNT_ONE;
                end
            end
            S_TAILW: begin
                if (cnt_r <= CNT_ONE) begin
                    state_nx_s = S_DONE;
                    done_nx_s  = 1'b1;
                    pass_nx_s  = (edges_nx_s == exp_r);
                end else begin
                    cnt_nx_s = cnt_r - CNT_ONE;
                end
            end
            S_DONE: begin
                state_nx_s = S_IDLE;
            end
            default: begin
                state_nx_s = S_IDLE;
            end
        endcase
    end

    // State and registered outputs; g and busy are decoded from the next state.
    always_ff @(posedge clk11m or posedge rst) begin
        if (rst) begin
            state_r <= S_IDLE;
            cnt_r   <= CNT_ZERO;
            pcnt_r  <= NW_ZERO;
            width_r <= CNT_ZERO;
            gap_r   <= CNT_ZERO;
            exp_r   <= NW_ZERO;
            edges_r <= NW_ZERO;
            pass_r  <= 1'b0;
            done_r  <= 1'b0;
            g_r     <= 1'b0;
            busy_r  <= 1'b0;
            i_q_r   <= 1'b0;
        end else begin
            state_r <= state_nx_s;
            cnt_r   <= cnt_nx_s;
            pcnt_r  <= pcnt_nx_s;
            width_r <= width_nx_s;
            gap_r   <= gap_nx_s;
            exp_r   <= exp_nx_s;
            edges_r <= edges_nx_s;
            pass_r  <= pass_nx_s;
            done_r  <= done_nx_s;
            g_r     <= (state_nx_s == S_PULSE);
            busy_r  <= (state_nx_s != S_IDLE);
            i_q_r   <= i;
        end
    end

endmodule

// File: tb/tb_pwf_gate_seq.sv
// Randomised scoreboard bench for pwf_gate_seq: the driver pushes expected per-cycle
// outputs and burst verdicts, a negedge monitor pops and compares them.
module tb_pwf_gate_seq;

    localparam int CW   = 8;
    localparam int NW   = 4;
    localparam int TAIL = 16;

    logic          clk11m;
    logic          rst;
    logic          start;
    logic [CW-1:0] width;
    logic [CW-1:0] gap;
    logic [NW-1:0] npulse;
    logic [NW-1:0] exp_edges;
    logic          i;
    logic          g;
    logic          busy;
    logic          done;
    logic          pass;
    logic [NW-1:0] edges;

    typedef struct packed {
        logic g;
        logic busy;
        logic done;
    } cyc_t;

    typedef struct packed {
        logic [NW-1:0] edges;
        logic          pass;
    } res_t;

    cyc_t cyc_q[$];
    res_t res_q[$];

    int checks   = 0;
    int failures = 0;

    pwf_gate_seq #(.CW(CW), .NW(NW), .TAIL(TAIL)) dut (
        .clk11m    (clk11m),
        .rst       (rst),
        .start     (start),
        .width     (width),
        .gap       (gap),
        .npulse    (npulse),
        .exp_edges (exp_edges),
        .i         (i),
        .g         (g),
        .busy      (busy),
        .done      (done),
        .pass      (pass),
        .edges     (edges)
    );

    initial clk11m = 1'b0;
    always #5 clk11m = ~clk11m;

    task automatic check(input string nm, input int act, input int expv);
        checks++;
        if (act != expv) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, expv, $time);
        end
    endtask

    // Monitor: compares each cycle against the scoreboard, and verdicts whenever done is seen.
    always @(negedge clk11m) begin
        if (!rst) begin
            if (cyc_q.size() > 0) begin
                cyc_t e;
                e = cyc_q.pop_front();
                check("g", g, e.g);
                check("busy", busy, e.busy);
                check("done", done, e.done);
            end else begin
                check("idle_g", g, 0);
                check("idle_busy", busy, 0);
                check("idle_done", done, 0);
            end
            if (done) begin
                if (res_q.size() == 0) begin
                    check("unexpected_done", 1, 0);
                end else begin
                    res_t r;
                    r = res_q.pop_front();
                    check("edges", edges, r.edges);
                    check("pass", pass, r.pass);
                end
            end
        end
    end

    // mode 0: random i; 1: i toggles every cycle; 2: random i plus starts while busy.
    task automatic run_burst(input int w, input int gp, input int np, input int mode);
        bit   iv [0:511];
        int   gpe, per, len, cnt, ex;
        res_t r;
        cyc_t c;
        gpe = (gp == 0) ? 1 : gp;
        per = w + gpe;
        len = (w == 0 || np == 0) ? 0 : np * per + TAIL;
        for (int k = 0; k <= len + 2; k++) begin
            iv[k] = (mode == 1) ? bit'(k % 2) : bit'($urandom % 2);
        end
        cnt = 0;
        for (int k = 1; k <= len; k++) begin
            if (iv[k] && !iv[k-1] && cnt < 15) cnt++;
        end
        ex = ($urandom % 2 == 1) ? cnt : int'($urandom % 16);
        r.edges = NW'(cnt);
        r.pass  = (ex == cnt);
        res_q.push_back(r);
        start     = 1'b1;
        width     = CW'(w);
        gap       = CW'(gp);
        npulse    = NW'(np);
        exp_edges = NW'(ex);
        i         = iv[0];
        for (int k = 0; k <= len + 1; k++) begin
            @(posedge clk11m);
            #1;
            start     = 1'b0;
            width     = CW'($urandom);
            gap       = CW'($urandom);
            npulse    = NW'($urandom);
            exp_edges = NW'($urandom);
            if (mode == 2 && len > 0 && (k == len / 2 || k == len)) start = 1'b1;
            i = iv[k+1];
            c.g    = (len > 0) && (k < np * per) && ((k % per) < w);
            c.busy = (k <= len);
            c.done = (k == len);
            cyc_q.push_back(c);
        end
        start = 1'b0;
        i     = 1'b0;
    endtask

    task automatic run_reset_mid_burst();
        cyc_t c;
        start     = 1'b1;
        width     = 8'd20;
        gap       = 8'd5;
        npulse    = 4'd2;
        exp_edges = 4'd0;
        i         = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(posedge clk11m);
            #1;
            start  = 1'b0;
            i      = bit'($urandom % 2);
            c.g    = 1'b1;
            c.busy = 1'b1;
            c.done = 1'b0;
            cyc_q.push_back(c);
        end
        @(posedge clk11m);
        #3;
        rst = 1'b1;
        #1;
        check("rst_g_async", g, 0);
        check("rst_busy_async", busy, 0);
        cyc_q.delete();
        repeat (2) @(posedge clk11m);
        #3;
        rst = 1'b0;
        i   = 1'b0;
        check("rst_edges", edges, 0);
        check("rst_pass", pass, 0);
        repeat (30) @(posedge clk11m);
        #1;
    endtask

    initial begin
        rst       = 1'b1;
        start     = 1'b0;
        width     = 8'd0;
        gap       = 8'd0;
        npulse    = 4'd0;
        exp_edges = 4'd0;
        i         = 1'b0;
        #1;
        check("reset_g", g, 0);
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        check("reset_pass", pass, 0);
        check("reset_edges", edges, 0);
        repeat (2) @(posedge clk11m);
        #3;
        rst = 1'b0;
        @(posedge clk11m);
        #1;

        run_burst(20, 5, 2, 0);
        run_burst(9, 5, 3, 0);
        run_burst(5, 3, 0, 0);
        run_burst(0, 5, 3, 0);
        run_burst(4, 0, 3, 0);
        run_burst(6, 2, 2, 2);
        run_burst(20, 5, 2, 1);
        run_reset_mid_burst();
        for (int n = 0; n < 25; n++) begin
            run_burst(int'($urandom_range(0, 12)), int'($urandom_range(0, 6)),
                      int'($urandom_range(0, 4)), int'($urandom_range(0, 2)));
            if ($urandom % 3 == 0) begin
                repeat (int'($urandom_range(1, 4))) @(posedge clk11m);
                #1;
            end
        end
        repeat (5) @(posedge clk11m);
        #1;
        check("cyc_queue_drained", cyc_q.size(), 0);
        check("res_queue_drained", res_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
